mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Iterative RV32M multiply/divide responder for the execute stage. It accepts a one-cycle start pulse with funct3 and two forwarded integer operands, computes over multiple cycles, and returns a one-cycle done pulse with a held 32-bit result. Its outputs feed the execute stage's multiply/divide start/done handshake and the writeback result mux.

## Interface
- Parameters: none. Fixed 32-bit datapath, 32 iterations.
- clk  input  1  clock
- rst_n  input  1  reset; asynchronous, active-low
- start_i  input  1  one-cycle start pulse from the execute stage (start AND is_MUL_DIV)
- ctrl_i  input  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
- src1_i  input  32  forwarded rs1 value
- src2_i  input  32  forwarded rs2 value
- flush_i  input  1  abort the in-flight operation (pipeline clear)
- busy_o  output  1  operation in flight (CALC or DONE)
- done_o  output  1  one-cycle completion pulse
- result_o  output  32  result; valid in the done_o cycle and held until the next accepted start

## Operation
- States: IDLE, CALC, DONE.
- IDLE + start_i + !flush_i: latch ctrl, operand magnitudes, and result sign. Load iteration counter to 31.
  - Fast case goes to DONE.
  - Otherwise goes to CALC.
- Fast cases:
  - Division by zero: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU remainder = src1.
  - Signed overflow, 0x80000000 / 0xFFFFFFFF: DIV 0x80000000, REM 0.
- Multiply:
  - Radix-2 shift-add on magnitudes into a 64-bit accumulator, one bit per cycle.
  - Signedness: MUL/MULH treat both operands as signed; MULHSU treats src1 signed, src2 unsigned; MULHU treats both unsigned.
  - Product sign = XOR of the signed operands' signs.
  - MUL returns bits [31:0]; the others return [63:32].
- Divide:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - Quotient sign = sign1 XOR sign2; remainder sign = sign of dividend (DIV/REM only).
- CALC:
  - Performs one iteration per cycle; the counter decrements.
  - At counter 0, the final step's result is sign-corrected (two's complement negate), selected, and registered into result_o. Next state is DONE.
- DONE: done_o=1 for exactly one cycle, then IDLE.
- start_i while busy_o: ignored; no state change.
- flush_i in any state: next state IDLE, no done_o, result_o unchanged. A start_i in the same cycle is ignored (flush wins).

## Timing
- Reset values: state IDLE, busy_o 0, done_o 0, result_o 0, counter 0, accumulators 0.
- All outputs are registered.
- Cycle 0 = start_i cycle.
- Iterative path: CALC cycles 1–32, done_o in cycle 33.
- Fast path: done_o in cycle 1.
- busy_o is 1 from cycle 1 through the done_o cycle inclusive.
- A new start_i is accepted in the cycle after done_o.
- Operands are sampled only in cycle 0; later changes on src1_i/src2_i are don't-care.
- rst_n asserted mid-operation returns all outputs to reset values immediately; no done_o.

## Configuration
- MUL_DIV_FAST_MUL_EN defined:
  - MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed multiplier (operands sign/zero-extended per ctrl) and take the fast path, with done_o in cycle 1.
  - Division is unchanged.
- Undefined: multiply uses the 32-iteration shift-add path (done_o in cycle 33), and no hardware multiplier is inferred.

## Structure
- Shared package mul_div_pkg holds:
  - funct3 constants (MD_MUL…MD_REMU)
  - state encoding (IDLE/CALC/DONE)
  - MD_ITERS = 32
  - divide-by-zero and overflow result constants
- One sub-module, mul_div_step: combinational single-iteration datapath that performs either the shift-add multiply step or the restoring-divide subtract/compare step on the 64-bit partial registers. It is instantiated once, and the FSM and sign handling stay in mul_div_unit.

## Test plan
- MUL 7 × 0xFFFFFFFD (-3) -> result 0xFFFFFFEB.
  - done_o in cycle 33 without MUL_DIV_FAST_MUL_EN; cycle 1 with it.
  - busy_o high cycles 1–done.
- MULH, MULHSU, MULHU on 0x80000000 × 0x80000000 -> 0x40000000, 0xC0000000, 0x40000000 respectively.
- DIV 0xFFFFFFF9 (-7) / 2 -> 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each with done_o in cycle 33.
- Special cases, each with done_o in cycle 1:
  - DIVU 5/0 -> 0xFFFFFFFF
  - REM 17/0 -> 17
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000
  - REM same operands -> 0
- Flush and restart:
  - DIV started, flush_i at cycle 10 -> no done_o, busy_o 0 at cycle 11, result_o holds previous value.
  - start_i at cycle 12 with DIVU 9/3 -> result 3, done_o at cycle 45.
- Back-to-back and reset:
  - start_i asserted during CALC is ignored (result matches first op).
  - start_i in the cycle after done_o is accepted.
  - rst_n pulled low at cycle 20 -> busy_o, done_o, result_o all 0, and no done_o afterwards.

Source files
------------

// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared funct3 codes, FSM states and special-case results for mul_div_unit
package mul_div_pkg;
  localparam logic [2:0] MD_MUL = 3'd0, MD_MULH = 3'd1, MD_MULHSU = 3'd2, MD_MULHU = 3'd3;
  localparam logic [2:0] MD_DIV = 3'd4, MD_DIVU = 3'd5, MD_REM = 3'd6, MD_REMU = 3'd7;
  localparam int MD_ITERS = 32;
  localparam logic [31:0] MD_DIV0_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] MD_OVF_Q = 32'h8000_0000;
  localparam logic [31:0] MD_OVF_R = 32'h0000_0000;
  typedef enum logic [1:0] {IDLE, CALC, DONE} md_state_t;
endpackage

// File: rtl/mul_div_step.sv
// mul_div_step: one shift-add multiply or restoring-divide iteration on the 64-bit partial register
module mul_div_step (
  input  logic        div_i,
  input  logic [63:0] acc_i,
  input  logic [31:0] opd_i,
  output logic [63:0] acc_o
);
  logic [32:0] sum, rem, diff;
  always_comb begin
    sum = {1'b0, acc_i[63:32]} + (acc_i[0] ? {1'b0, opd_i} : 33'd0);
    rem = acc_i[63:31];
    diff = rem - {1'b0, opd_i};
    acc_o = !div_i ? {sum, acc_i[31:1]} :
            diff[32] ? {rem[31:0], acc_i[30:0], 1'b0} : {diff[31:0], acc_i[30:0], 1'b1};
  end
endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide; MUL_DIV_FAST_MUL_EN selects a single-cycle multiplier
module mul_div_unit
  import mul_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [2:0]  ctrl_i,
  input  logic [31:0] src1_i,
  input  logic [31:0] src2_i,
  input  logic        flush_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o
);
  md_state_t state;
  logic [2:0] ctrl;
  logic [63:0] acc, acc_nxt, prod_c;
  logic [31:0] opd, m1, m2, fast_res, mul_res, quo_c, calc_res;
  logic [4:0] cnt;
  logic neg, is_div, s1, s2, n1, n2, div0, ovf, fast;
`ifdef MUL_DIV_FAST_MUL_EN
  logic signed [65:0] prod;
`endif
  mul_div_step u_step (.div_i(ctrl[2]), .acc_i(acc), .opd_i(opd), .acc_o(acc_nxt));
  always_comb begin
    is_div = ctrl_i[2];
    s1 = ctrl_i != MD_MULHU && ctrl_i != MD_DIVU && ctrl_i != MD_REMU;
    s2 = ctrl_i == MD_MUL || ctrl_i == MD_MULH || ctrl_i == MD_DIV || ctrl_i == MD_REM;
    n1 = s1 & src1_i[31];
    n2 = s2 & src2_i[31];
    m1 = n1 ? -src1_i : src1_i;
    m2 = n2 ? -src2_i : src2_i;
    div0 = is_div && src2_i == '0;
    ovf = (ctrl_i == MD_DIV || ctrl_i == MD_REM) && src1_i == MD_OVF_Q && src2_i == '1;
`ifdef MUL_DIV_FAST_MUL_EN
    prod = $signed({n1, src1_i}) * $signed({n2, src2_i});
    fast = div0 | ovf | !is_div;
    mul_res = ctrl_i == MD_MUL ? prod[31:0] : prod[63:32];
`else
    fast = div0 | ovf;
    mul_res = '0;
`endif
    fast_res = div0 ? (ctrl_i[1] ? src1_i : MD_DIV0_Q) :
               ovf ? (ctrl_i[1] ? MD_OVF_R : MD_OVF_Q) : mul_res;
    prod_c = neg ? -acc_nxt : acc_nxt;
    quo_c = ctrl[1] ? acc_nxt[63:32] : acc_nxt[31:0];
    calc_res = !ctrl[2] ? (ctrl == MD_MUL ? prod_c[31:0] : prod_c[63:32]) : (neg ? -quo_c : quo_c);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ctrl <= '0;
      acc <= '0;
      opd <= '0;
      neg <= 1'b0;
      cnt <= '0;
      busy_o <= 1'b0;
      done_o <= 1'b0;
      result_o <= '0;
    end else if (flush_i) begin
      state <= IDLE;
      busy_o <= 1'b0;
      done_o <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start_i) begin
          ctrl <= ctrl_i;
          neg <= is_div && ctrl_i[1] ? n1 : n1 ^ n2;
          cnt <= 5'(MD_ITERS - 1);
          acc <= {32'd0, is_div ? m1 : m2};
          opd <= is_div ? m2 : m1;
          busy_o <= 1'b1;
          done_o <= fast;
          result_o <= fast ? fast_res : result_o;
          state <= fast ? DONE : CALC;
        end
        CALC: begin
          acc <= acc_nxt;
          cnt <= cnt - 5'd1;
          if (cnt == '0) begin
            result_o <= calc_res;
            done_o <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done_o <= 1'b0;
          busy_o <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: directed vectors plus a cycle-level reference model for mul_div_unit
module tb_mul_div_unit;
`ifdef MUL_DIV_FAST_MUL_EN
  localparam int ML = 1;
`else
  localparam int ML = 33;
`endif
  logic clk = 0, rst_n = 1, start = 0, flush = 0;
  logic [2:0] ctrl = 0;
  logic [31:0] src1 = 0, src2 = 0;
  logic busy_o, done_o;
  logic [31:0] result_o;
  int n_pass = 0, n_tot = 0;
  logic m_busy = 0, m_done = 0;
  logic [31:0] m_res = 0, m_pend = 0;
  int m_left = 0;

  mul_div_unit dut (.clk(clk), .rst_n(rst_n), .start_i(start), .ctrl_i(ctrl), .src1_i(src1),
    .src2_i(src2), .flush_i(flush), .busy_o(busy_o), .done_o(done_o), .result_o(result_o));

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_res(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'd0, a});
    longint ub = longint'({32'd0, b});
    logic [63:0] p;
    case (c)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return b == 0 ? 32'hFFFF_FFFF : 32'(sa / sb);
      3'd5: return b == 0 ? 32'hFFFF_FFFF : a / b;
      3'd6: return b == 0 ? a : 32'(sa % sb);
      default: return b == 0 ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
    if (!c[2]) return ML;
    if (b == 0) return 1;
    if (!c[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s got %h exp %h at %0t", nm, got, exp, $time);
    else n_pass++;
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      m_busy <= 0; m_done <= 0; m_res <= 0; m_left <= 0;
    end else if (flush) begin
      m_busy <= 0; m_done <= 0;
    end else if (m_done) begin
      m_busy <= 0; m_done <= 0;
    end else if (m_busy) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin m_done <= 1; m_res <= m_pend; end
    end else if (start) begin
      m_busy <= 1;
      m_pend <= ref_res(ctrl, src1, src2);
      m_left <= ref_lat(ctrl, src1, src2) - 1;
      if (ref_lat(ctrl, src1, src2) == 1) begin m_done <= 1; m_res <= ref_res(ctrl, src1, src2); end
    end

  always @(negedge clk) begin
    #2;
    chk("model busy", {31'd0, busy_o}, {31'd0, m_busy});
    chk("model done", {31'd0, done_o}, {31'd0, m_done});
    chk("model result", result_o, m_res);
  end

  task automatic run_op(input string nm, input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] er, input int el);
    int n;
    @(negedge clk);
    start = 1; ctrl = c; src1 = a; src2 = b;
    @(negedge clk);
    start = 0; src1 = $urandom; src2 = $urandom;
    chk({nm, " busy c1"}, {31'd0, busy_o}, 32'd1);
    n = 1;
    while (!done_o && n < 100) begin @(negedge clk); n++; end
    chk({nm, " lat"}, n, el);
    chk({nm, " res"}, result_o, er);
  endtask

  initial begin
    int n;
    logic seen;
    #3 rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk("reset busy", {31'd0, busy_o}, 0);
    chk("reset done", {31'd0, done_o}, 0);
    chk("reset result", result_o, 0);
    run_op("MUL 7*-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, ML);
    run_op("MULH", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML);
    run_op("MULHSU", 3'd2, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, ML);
    run_op("MULHU", 3'd3, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, ML);
    run_op("MULHSU mix", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, ML);
    run_op("DIV -7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("REM -7%2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("DIVU 100/7", 3'd5, 32'd100, 32'd7, 32'd14, 33);
    run_op("REMU 100/7", 3'd7, 32'd100, 32'd7, 32'd2, 33);
    run_op("DIV 100/-7", 3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33);
    run_op("DIVU 5/0", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("DIV ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("REM ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("REM 17/0", 3'd6, 32'd17, 32'd0, 32'd17, 1);
    // flush at cycle 10, restart at cycle 12
    @(negedge clk);
    start = 1; ctrl = 3'd4; src1 = 32'd1000; src2 = 32'd3;
    seen = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      seen |= done_o;
      start = 0; flush = (i == 10);
      if (i == 11) begin
        chk("flush busy", {31'd0, busy_o}, 0);
        chk("flush result held", result_o, 32'd17);
      end
      if (i == 12) begin start = 1; ctrl = 3'd5; src1 = 32'd9; src2 = 32'd3; end
    end
    chk("flush no done", {31'd0, seen}, 0);
    @(negedge clk);
    start = 0;
    n = 13;
    while (!done_o && n < 100) begin @(negedge clk); n++; end
    chk("restart lat", n, 45);
    chk("restart res", result_o, 32'd3);
    // start while busy is ignored, start right after done is accepted
    @(negedge clk);
    start = 1; ctrl = 3'd5; src1 = 32'd100; src2 = 32'd7;
    n = 0;
    while (!done_o && n < 100) begin
      @(negedge clk);
      n++;
      start = (n == 5);
      if (n == 5) begin ctrl = 3'd0; src1 = 32'd2; src2 = 32'd3; end
    end
    chk("ignored start lat", n, 33);
    chk("ignored start res", result_o, 32'd14);
    run_op("b2b MUL 6*7", 3'd0, 32'd6, 32'd7, 32'd42, ML);
    // reset in the middle of a divide
    @(negedge clk);
    start = 1; ctrl = 3'd4; src1 = 32'd12345; src2 = 32'd11;
    for (int i = 1; i <= 20; i++) begin @(negedge clk); start = 0; end
    rst_n = 0;
    #1;
    chk("midrst busy", {31'd0, busy_o}, 0);
    chk("midrst done", {31'd0, done_o}, 0);
    chk("midrst result", result_o, 0);
    @(negedge clk);
    rst_n = 1;
    seen = 0;
    repeat (40) begin @(negedge clk); seen |= done_o; end
    chk("midrst no done", {31'd0, seen}, 0);
    run_op("post-rst REMU", 3'd7, 32'hFFFF_FFFF, 32'd10, 32'd5, 33);
    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
